ff_fifo: RTL and testbench
==========================

Name: ff_fifo

Overview:
- Synchronous FIFO with a valid/ready handshake on both sides, built for the 74-series standard-cell flow.
- It generates the per-entry write enables and read selection. Its storage is an array of enable flip-flops (mux-recirculating DFFs, no reset).
- It sits upstream of the enable-flop storage: it drives `en`/`d` into those cells and muxes their `q` back out.
- Used as a decoupling buffer between bus stages on the discrete-logic boards.

Parameters:
- WIDTH, 8, data bits per entry (≥1).
- DEPTH, 4, number of entries; must be a power of two and ≥2.
- PTR_W, $clog2(DEPTH), derived; read/write pointer index width. Not to be overridden.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- valid_i  input  1  upstream presents data_i.
- ready_o  output  1  FIFO accepts data this cycle.
- data_i  input  WIDTH  write data.
- valid_o  output  1  data_o holds the oldest entry.
- ready_i  input  1  downstream consumes data_o this cycle.
- data_o  output  WIDTH  read data (head entry).
- usage_o  output  PTR_W+1  current fill level, 0..DEPTH.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each PTR_W+1 bits; the MSB is the wrap bit.
  - Storage: DEPTH x WIDTH enable flops with no reset.
- Reset (rst_i high, asynchronous, any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0.
  - Outputs during and after reset: valid_o=0, ready_o=1, usage_o=0.
  - Storage contents are not cleared; data_o is don't-care while valid_o=0.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) and (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]).
  - ready_o = !full; valid_o = !empty.
  - Both depend only on registered state: no combinational path from valid_i to valid_o or from ready_i to ready_o.
- Push (valid_i && ready_o at the rising edge):
  - The entry at wr_ptr[PTR_W-1:0] gets en=1 and loads data_i.
  - wr_ptr increments by 1, modulo 2^(PTR_W+1).
  - All other entries have en=0 and hold.
- Pop (valid_o && ready_i at the rising edge): rd_ptr increments by 1, modulo 2^(PTR_W+1).
- data_o = storage[rd_ptr[PTR_W-1:0]], a combinational read mux.
- Latency: no fall-through. Data pushed into an empty FIFO appears with valid_o=1 on the cycle after the accepting edge.
- Simultaneous push and pop:
  - Both pointers advance; usage unchanged.
  - Allowed whenever neither side is blocked, i.e. neither empty nor full.
  - When full, ready_o=0, so the push is refused even if a pop happens on the same edge. The freed slot is visible next cycle.
  - When empty, the pop is refused because valid_o=0.
- Wrap-around: pointer index bits wrap DEPTH-1→0 and the wrap bit toggles. Behaviour is identical across any number of wraps.
- usage_o = wr_ptr - rd_ptr, taken mod 2^(PTR_W+1). Registered-state derived, glitch-free relative to the clock.
- valid_i while ready_o=0: ignored, no state change. Upstream holds data per protocol; the FIFO does not check.
- Data ordering strictly preserved. No entry is lost or duplicated.

Decomposition:
- Shared package `ff_fifo_pkg`: holds the DEPTH power-of-two check helper and the usage/pointer width function (clog2+1). No typedefs beyond `logic` vectors.
- One sub-module, `fifo_ptr`:
  - Counter with increment enable, async reset to 0, PTR_W+1 bits.
  - Instantiated twice, for write and read.
  - Write-enable decode and read mux stay in `ff_fifo`.
  - Storage uses the team's existing enable-flop cell per bit.

Test Plan:
- Reset:
  - Stimulus: assert rst_i mid-cycle with 2 entries stored.
  - Required: immediately (no clock edge) valid_o=0, ready_o=1, usage_o=0; after release, the first pop waits for a new push.
- Fill/drain (DEPTH=4, WIDTH=8):
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 with ready_i=0.
  - Required: usage_o 1,2,3,4; ready_o=0 after the 4th push; a 5th push of 0x55 is ignored. Then ready_i=1: data_o 0x11,0x22,0x33,0x44, then valid_o=0.
- Latency:
  - Stimulus: push 0xA5 into an empty FIFO at edge N.
  - Required: valid_o=0 before edge N; valid_o=1 and data_o=0xA5 after edge N.
- Simultaneous:
  - Stimulus: with 2 entries stored, valid_i=ready_i=1 for 10 cycles with an incrementing payload.
  - Required: usage_o stays 2; output sequence equals input sequence delayed by 2 pops.
- Full plus pop:
  - Stimulus: full FIFO, valid_i=1 and ready_i=1 on the same edge.
  - Required: only the pop occurs; usage_o 4→3; ready_o=1 next cycle.
- Wrap stress:
  - Stimulus: 1000 cycles of random valid_i/ready_i with a scoreboard.
  - Required: zero mismatches, usage_o never >4, and no push accepted when full or pop accepted when empty.

Source files
------------

// File: rtl/ff_fifo_pkg.sv
// Shared sizing helpers for the enable-flop FIFO: depth legality and pointer width.
package ff_fifo_pkg;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    // Pointer width including the wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with increment enable, async reset to zero.
// One-cycle update on the rising edge; no backpressure of its own.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ff_fifo.sv
// Valid/ready FIFO over no-reset enable-flop storage; head visible the cycle after the push edge.
// ready_o/valid_o come from registered pointers only; push refused when full, pop refused when empty.
module ff_fifo
    import ff_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [PTR_W:0]   usage_o
);

    localparam int CNT_W = ptr_w(DEPTH);

    generate
        if (!is_pow2(DEPTH) || CNT_W != PTR_W + 1) begin : g_bad_depth
            $error("ff_fifo: DEPTH must be a power of two >= 2 and PTR_W left at its default");
        end
    endgenerate

    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] wr_en;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign ready_o = !full;
    assign valid_o = !empty;
    assign push    = valid_i && !full;
    assign pop     = ready_i && !empty;

    fifo_ptr #(.W(PTR_W + 1)) u_wr_ptr (
        .clk (clk_i),
        .rst (rst_i),
        .inc (push),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.W(PTR_W + 1)) u_rd_ptr (
        .clk (clk_i),
        .rst (rst_i),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // One-hot entry enable; every other entry recirculates its own value.
    always_comb begin
        wr_en = '0;
        wr_en[wr_ptr[PTR_W-1:0]] = push;
    end

    // Storage is deliberately not reset; data_o is only meaningful with valid_o.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem[i] <= data_i;
            end
        end
    end

    assign data_o  = mem[rd_ptr[PTR_W-1:0]];
    assign usage_o = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_ff_fifo.sv
// Bench for ff_fifo: queue reference model checked every cycle, plus directed literal expectations.
module tb_ff_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [WIDTH-1:0] data_i = '0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] data_o;
    logic [PTR_W:0]   usage_o;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] q[$];

    ff_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .usage_o (usage_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO is a bounded queue.
    always @(posedge rst_i) q.delete();

    always @(posedge clk_i) begin
        if (!rst_i) begin
            bit do_push;
            bit do_pop;
            do_push = valid_i && (q.size() < DEPTH);
            do_pop  = ready_i && (q.size() > 0);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(data_i);
        end
    end

    always @(negedge clk_i) begin
        chk("model_valid", int'(valid_o), int'(q.size() != 0));
        chk("model_ready", int'(ready_o), int'(q.size() < DEPTH));
        chk("model_usage", int'(usage_o), q.size());
        if (q.size() != 0) chk("model_data", int'(data_o), int'(q[0]));
    end

    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_ready", int'(ready_o), 1);
        chk("rst_usage", int'(usage_o), 0);
        rst_i = 1'b0;

        // Fill with the downstream stalled, then attempt an overflow push.
        cycle(1, 8'h11, 0); chk("fill_usage1", int'(usage_o), 1);
        cycle(1, 8'h22, 0); chk("fill_usage2", int'(usage_o), 2);
        cycle(1, 8'h33, 0); chk("fill_usage3", int'(usage_o), 3);
        cycle(1, 8'h44, 0); chk("fill_usage4", int'(usage_o), 4);
        chk("full_ready", int'(ready_o), 0);
        cycle(1, 8'h55, 0); chk("overflow_usage", int'(usage_o), 4);
        chk("drain_d0", int'(data_o), 8'h11);
        cycle(0, 8'h00, 1); chk("drain_d1", int'(data_o), 8'h22);
        cycle(0, 8'h00, 1); chk("drain_d2", int'(data_o), 8'h33);
        cycle(0, 8'h00, 1); chk("drain_d3", int'(data_o), 8'h44);
        cycle(0, 8'h00, 1); chk("drain_empty", int'(valid_o), 0);

        // Latency: no fall-through.
        chk("lat_before", int'(valid_o), 0);
        cycle(1, 8'hA5, 0);
        chk("lat_valid", int'(valid_o), 1);
        chk("lat_data", int'(data_o), 8'hA5);
        cycle(0, 8'h00, 1);

        // Simultaneous push/pop with two entries resident.
        cycle(1, 8'h00, 0);
        cycle(1, 8'h01, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 8'(i + 2), 1);
            chk("sim_usage", int'(usage_o), 2);
            chk("sim_data", int'(data_o), i + 1);
        end
        cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 1);
        chk("sim_empty", int'(valid_o), 0);

        // Full plus pop on the same edge: only the pop happens.
        cycle(1, 8'h61, 0);
        cycle(1, 8'h62, 0);
        cycle(1, 8'h63, 0);
        cycle(1, 8'h64, 0);
        cycle(1, 8'h99, 1);
        chk("fullpop_usage", int'(usage_o), 3);
        chk("fullpop_ready", int'(ready_o), 1);
        chk("fullpop_head", int'(data_o), 8'h62);
        repeat (3) cycle(0, 8'h00, 1);
        chk("fullpop_empty", int'(valid_o), 0);

        // Asynchronous reset mid-cycle with two entries stored.
        cycle(1, 8'h71, 0);
        cycle(1, 8'h72, 0);
        valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", int'(valid_o), 0);
        chk("arst_ready", int'(ready_o), 1);
        chk("arst_usage", int'(usage_o), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cycle(0, 8'h00, 1); chk("post_rst_nopop", int'(valid_o), 0);
        cycle(1, 8'h5A, 0);
        chk("post_rst_valid", int'(valid_o), 1);
        chk("post_rst_data", int'(data_o), 8'h5A);
        cycle(0, 8'h00, 1);

        // Random traffic across many wraps; the model checks every cycle.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (DEPTH) cycle(0, 8'h00, 1);
        chk("final_empty", int'(valid_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
